// File: rtl/mem_port_arbiter.sv
// Shared memory port for IF/MEM (MEM wins); a grant taken in IDLE drives the bus next cycle and holds until ack.
// Requesters are stalled until their valid strobe; MEM_ARB_TIMEOUT_EN adds a per-transaction abort timer and sticky o_busErr.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Fi_req,
  input  logic [31:0] Fi_addr,
  input  logic        Mi_memReq,
  input  logic        Mi_memWrite,
  input  logic [1:0]  Mi_memSize,
  input  logic [31:0] Mi_addr,
  input  logic [31:0] Mi_wdata,
  output logic        o_busReq,
  output logic        o_busWrite,
  output logic [1:0]  o_busSize,
  output logic [31:0] o_busAddr,
  output logic [31:0] o_busWdata,
  input  logic        i_busAck,
  input  logic [31:0] i_busRdata,
  output logic [31:0] Fo_inst,
  output logic        Fo_instValid,
  output logic [31:0] Mo_rdata,
  output logic        Mo_dataValid,
  output logic        o_stallF,
  output logic        o_stallM,
  output logic        o_busErr
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        tmo;
  logic        done;
  logic [31:0] rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter is zero in the first bus cycle, so it reads TIMEOUT-1 in the TIMEOUT-th one.
  always_comb begin
    tmo   = (state_q != IDLE) && !i_busAck && (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!i_busAck) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | tmo;
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_busErr = err_q;
`else
  assign tmo      = 1'b0;
  assign o_busErr = 1'b0;
`endif

  always_comb begin
    done    = (state_q != IDLE) && (i_busAck || tmo);
    state_d = state_q;
    req_d   = req_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (Mi_memReq) begin
          state_d = DATA;
          req_d   = 1'b1;
          write_d = Mi_memWrite;
          size_d  = Mi_memSize;
          addr_d  = Mi_addr;
          wdata_d = Mi_wdata;
        end else if (Fi_req) begin
          state_d = FETCH;
          req_d   = 1'b1;
          write_d = 1'b0;
          size_d  = 2'b10;
          addr_d  = Fi_addr;
          wdata_d = 32'h0;
        end
      end
      FETCH, DATA: begin
        // Always fall back to IDLE so a requester's stale request is never re-served.
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rdata        = tmo ? 32'h0 : i_busRdata;
  assign Fo_inst      = rdata;
  assign Mo_rdata     = rdata;
  assign Fo_instValid = (state_q == FETCH) && done && Fi_req;
  assign Mo_dataValid = (state_q == DATA) && done;
  assign o_stallF     = Fi_req & ~Fo_instValid;
  assign o_stallM     = Mi_memReq & ~Mo_dataValid;

  assign o_busReq   = req_q;
  assign o_busWrite = write_q;
  assign o_busSize  = size_q;
  assign o_busAddr  = addr_q;
  assign o_busWdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand sequences for flush/reset/timeout, then random traffic vs a transaction model.
module tb_mem_port_arbiter;
  localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_x;
  logic        Fi_req;
  logic [31:0] Fi_addr;
  logic        Mi_memReq;
  logic        Mi_memWrite;
  logic [1:0]  Mi_memSize;
  logic [31:0] Mi_addr;
  logic [31:0] Mi_wdata;
  logic        o_busReq;
  logic        o_busWrite;
  logic [1:0]  o_busSize;
  logic [31:0] o_busAddr;
  logic [31:0] o_busWdata;
  logic        i_busAck;
  logic [31:0] i_busRdata;
  logic [31:0] Fo_inst;
  logic        Fo_instValid;
  logic [31:0] Mo_rdata;
  logic        Mo_dataValid;
  logic        o_stallF;
  logic        o_stallM;
  logic        o_busErr;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_x(reset_x),
    .Fi_req(Fi_req), .Fi_addr(Fi_addr),
    .Mi_memReq(Mi_memReq), .Mi_memWrite(Mi_memWrite), .Mi_memSize(Mi_memSize),
    .Mi_addr(Mi_addr), .Mi_wdata(Mi_wdata),
    .o_busReq(o_busReq), .o_busWrite(o_busWrite), .o_busSize(o_busSize),
    .o_busAddr(o_busAddr), .o_busWdata(o_busWdata),
    .i_busAck(i_busAck), .i_busRdata(i_busRdata),
    .Fo_inst(Fo_inst), .Fo_instValid(Fo_instValid),
    .Mo_rdata(Mo_rdata), .Mo_dataValid(Mo_dataValid),
    .o_stallF(o_stallF), .o_stallM(o_stallM), .o_busErr(o_busErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one outstanding bus transaction and its age in bus cycles.
  bit          m_busy, m_fetch, m_wr, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  int          m_age;

  function automatic void m_finish(output bit dn, output bit to);
    to = TMO_EN && m_busy && !i_busAck && (m_age == TO);
    dn = m_busy && (i_busAck || to);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_fetch = 0; m_wr = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_size = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit dn, to;
    m_finish(dn, to);
    if (m_busy) begin
      if (dn) begin
        m_busy = 0;
        if (to) m_err = 1;
      end else begin
        m_age++;
      end
    end else if (Mi_memReq) begin
      m_busy = 1; m_fetch = 0; m_addr = Mi_addr; m_wr = Mi_memWrite;
      m_size = Mi_memSize; m_wdata = Mi_wdata; m_age = 1;
    end else if (Fi_req) begin
      m_busy = 1; m_fetch = 1; m_addr = Fi_addr; m_wr = 0;
      m_size = 2'b10; m_wdata = 0; m_age = 1;
    end
  endtask

  task automatic check_all();
    bit dn, to, fv, dv;
    m_finish(dn, to);
    fv = dn && m_fetch && Fi_req;
    dv = dn && !m_fetch;
    chk1("rnd_busReq", o_busReq, m_busy);
    if (m_busy) begin
      chk32("rnd_busAddr", o_busAddr, m_addr);
      chk1("rnd_busWrite", o_busWrite, m_wr);
      chk32("rnd_busSize", {30'b0, o_busSize}, {30'b0, m_size});
      chk32("rnd_busWdata", o_busWdata, m_wdata);
    end
    chk1("rnd_instValid", Fo_instValid, fv);
    chk1("rnd_dataValid", Mo_dataValid, dv);
    chk32("rnd_inst", Fo_inst, to ? 32'h0 : i_busRdata);
    chk32("rnd_rdata", Mo_rdata, to ? 32'h0 : i_busRdata);
    chk1("rnd_stallF", o_stallF, Fi_req & ~fv);
    chk1("rnd_stallM", o_stallM, Mi_memReq & ~dv);
    chk1("rnd_busErr", o_busErr, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_x = 1'b0;
    Fi_req = 1; Mi_memReq = 1; i_busAck = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk1("rst_busReq", o_busReq, 1'b0);
    chk1("rst_busWrite", o_busWrite, 1'b0);
    chk32("rst_busSize", {30'b0, o_busSize}, 32'h0);
    chk32("rst_busAddr", o_busAddr, 32'h0);
    chk32("rst_busWdata", o_busWdata, 32'h0);
    chk1("rst_busErr", o_busErr, 1'b0);
    chk1("rst_instValid", Fo_instValid, 1'b0);
    chk1("rst_dataValid", Mo_dataValid, 1'b0);
    chk1("rst_stallF", o_stallF, 1'b1);
    chk1("rst_stallM", o_stallM, 1'b1);
    Fi_req = 0; Mi_memReq = 0;
    reset_x = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        fi, mi, ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_wr;
    logic        exp_fv, exp_dv, exp_sf, exp_sm;
  } vec_t;

  function automatic vec_t mk(logic fi, logic mi, logic ack, logic req, logic [31:0] addr,
                              logic wr, logic fv, logic dv, logic sf, logic sm);
    vec_t v;
    v.fi = fi; v.mi = mi; v.ack = ack; v.exp_req = req; v.exp_addr = addr; v.exp_wr = wr;
    v.exp_fv = fv; v.exp_dv = dv; v.exp_sf = sf; v.exp_sm = sm;
    return v;
  endfunction

  vec_t vt[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Collision (store first, turnaround, then fetch), fetch-only with ack two cycles late, ack in IDLE.
    vt[0]  = mk(1, 1, 0,  0, 32'h0,    0,  0, 0, 1, 1);
    vt[1]  = mk(1, 1, 0,  1, 32'h2000, 1,  0, 0, 1, 1);
    vt[2]  = mk(1, 1, 1,  1, 32'h2000, 1,  0, 1, 1, 0);
    vt[3]  = mk(1, 0, 0,  0, 32'h0,    0,  0, 0, 1, 0);
    vt[4]  = mk(1, 0, 0,  1, 32'h100,  0,  0, 0, 1, 0);
    vt[5]  = mk(1, 0, 1,  1, 32'h100,  0,  1, 0, 0, 0);
    vt[6]  = mk(0, 0, 0,  0, 32'h0,    0,  0, 0, 0, 0);
    vt[7]  = mk(1, 0, 0,  0, 32'h0,    0,  0, 0, 1, 0);
    vt[8]  = mk(1, 0, 0,  1, 32'h100,  0,  0, 0, 1, 0);
    vt[9]  = mk(1, 0, 0,  1, 32'h100,  0,  0, 0, 1, 0);
    vt[10] = mk(1, 0, 1,  1, 32'h100,  0,  1, 0, 0, 0);
    vt[11] = mk(0, 0, 1,  0, 32'h0,    0,  0, 0, 0, 0);

    Fi_addr = 32'h100; Mi_addr = 32'h2000; Mi_memWrite = 1; Mi_memSize = 2'b10;
    Mi_wdata = 32'hDEADBEEF; i_busRdata = 32'h00A00093;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      Fi_req = vt[i].fi; Mi_memReq = vt[i].mi; i_busAck = vt[i].ack;
      @(negedge clk);
      chk1($sformatf("vec%0d_busReq", i), o_busReq, vt[i].exp_req);
      if (vt[i].exp_req) begin
        chk32($sformatf("vec%0d_busAddr", i), o_busAddr, vt[i].exp_addr);
        chk1($sformatf("vec%0d_busWrite", i), o_busWrite, vt[i].exp_wr);
        chk32($sformatf("vec%0d_busSize", i), {30'b0, o_busSize}, 32'h2);
        chk32($sformatf("vec%0d_busWdata", i), o_busWdata, vt[i].exp_wr ? 32'hDEADBEEF : 32'h0);
      end
      chk1($sformatf("vec%0d_instValid", i), Fo_instValid, vt[i].exp_fv);
      chk1($sformatf("vec%0d_dataValid", i), Mo_dataValid, vt[i].exp_dv);
      chk1($sformatf("vec%0d_stallF", i), o_stallF, vt[i].exp_sf);
      chk1($sformatf("vec%0d_stallM", i), o_stallM, vt[i].exp_sm);
      if (vt[i].exp_fv) chk32($sformatf("vec%0d_inst", i), Fo_inst, 32'h00A00093);
      tick();
    end

    // Flush: fetch request withdrawn while the bus cycle is in flight.
    do_reset();
    Fi_req = 1; i_busAck = 0;
    tick();
    Fi_req = 0;
    @(negedge clk);
    chk1("flush_busReq", o_busReq, 1'b1);
    chk1("flush_stallF", o_stallF, 1'b0);
    tick();
    i_busAck = 1;
    @(negedge clk);
    chk1("flush_instValid", Fo_instValid, 1'b0);
    tick();
    i_busAck = 0;
    @(negedge clk);
    chk1("flush_idle_busReq", o_busReq, 1'b0);
    tick();

    // Reset asserted between edges while a load is on the bus.
    do_reset();
    Mi_memReq = 1; Mi_memWrite = 0; Mi_addr = 32'h3000;
    tick();
    @(negedge clk);
    chk1("rstdata_busReq_before", o_busReq, 1'b1);
    @(posedge clk);
    #2;
    i_busAck = 1;
    reset_x = 0;
    #1;
    chk1("rstdata_busReq", o_busReq, 1'b0);
    chk1("rstdata_dataValid", Mo_dataValid, 1'b0);
    chk1("rstdata_stallM", o_stallM, 1'b1);
    tick();
    i_busAck = 0;
    Mi_memReq = 0;
    reset_x = 1;
    model_reset();

`ifdef MEM_ARB_TIMEOUT_EN
    // Load never acked: forced completion in bus cycle TO with zero data, sticky error.
    do_reset();
    Mi_memReq = 1; Mi_memWrite = 0; Mi_addr = 32'h40; i_busRdata = 32'h12345678; i_busAck = 0;
    tick();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      chk1($sformatf("tmo_c%0d_dataValid", c), Mo_dataValid, c == TO);
      chk1($sformatf("tmo_c%0d_busErr", c), o_busErr, 1'b0);
      if (c == TO) chk32("tmo_rdata", Mo_rdata, 32'h0);
      tick();
    end
    Mi_memReq = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1($sformatf("tmo_sticky%0d_busErr", c), o_busErr, 1'b1);
      chk1($sformatf("tmo_sticky%0d_busReq", c), o_busReq, 1'b0);
      tick();
    end

    // Ack arriving in the timeout cycle completes normally.
    do_reset();
    Mi_memReq = 1; Mi_memWrite = 0; Mi_addr = 32'h44; i_busAck = 0;
    tick();
    for (int c = 1; c <= TO; c++) begin
      i_busAck = (c == TO);
      @(negedge clk);
      chk1($sformatf("tmoack_c%0d_dataValid", c), Mo_dataValid, c == TO);
      if (c == TO) chk32("tmoack_rdata", Mo_rdata, 32'h12345678);
      tick();
    end
    Mi_memReq = 0; i_busAck = 0;
    @(negedge clk);
    chk1("tmoack_busErr", o_busErr, 1'b0);
    tick();
`endif

    // Random traffic against the transaction model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      Fi_req      = ($urandom_range(0, 99) < 60);
      Mi_memReq   = ($urandom_range(0, 99) < 40);
      Mi_memWrite = $urandom_range(0, 1);
      Mi_memSize  = 2'($urandom_range(0, 3));
      Fi_addr     = $urandom;
      Mi_addr     = $urandom;
      Mi_wdata    = $urandom;
      i_busAck    = ($urandom_range(0, 99) < 35);
      i_busRdata  = $urandom;
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
